// File: rtl/tone_bank.sv
// Bank of NUM_KEYS debounced tone generators with a highest-index-wins speaker mix.
// Optional feature: define TONE_BANK_OCTAVE_EN to add the octave_up port (halves the latched half-period).
module tone_bank #(
  parameter int NUM_KEYS    = 8,
  parameter int DIV_W       = 32,
  parameter int HOLD_CYCLES = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_KEYS-1:0]       key_in,
  input  logic [NUM_KEYS*DIV_W-1:0] half_period,
`ifdef TONE_BANK_OCTAVE_EN
  input  logic                      octave_up,
`endif
  output logic [NUM_KEYS-1:0]       tone_out,
  output logic [NUM_KEYS-1:0]       active,
  output logic                      speaker
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ATTACK  = 2'd1,
    S_PLAY    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t             state_q  [NUM_KEYS];
  logic [HOLD_W-1:0]  hold_q   [NUM_KEYS];
  logic [DIV_W-1:0]   div_q    [NUM_KEYS];
  logic [DIV_W-1:0]   hp_q     [NUM_KEYS];
  logic [DIV_W-1:0]   sel_hp   [NUM_KEYS];
  logic [DIV_W-1:0]   entry_hp [NUM_KEYS];
  logic [NUM_KEYS-1:0] play_entry;
  logic               speaker_next;

  // Half-period captured on PLAY entry; zero is promoted to one so the divider never stalls.
  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      sel_hp[i] = half_period[i*DIV_W +: DIV_W];
`ifdef TONE_BANK_OCTAVE_EN
      if (octave_up) sel_hp[i] = sel_hp[i] >> 1;
`endif
      entry_hp[i] = (sel_hp[i] == '0) ? DIV_W'(1) : sel_hp[i];
    end
  end

  always_comb begin
    play_entry = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (key_in[i]) begin
        if (state_q[i] == S_IDLE && HOLD_CYCLES == 1) play_entry[i] = 1'b1;
        if (state_q[i] == S_ATTACK && hold_q[i] == HOLD_LAST) play_entry[i] = 1'b1;
      end
    end
  end

  always_comb begin
    speaker_next = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (active[i]) speaker_next = tone_out[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_q[i] <= S_IDLE;
        hold_q[i]  <= '0;
        div_q[i]   <= '0;
        hp_q[i]    <= '0;
      end
      tone_out <= '0;
      active   <= '0;
      speaker  <= 1'b0;
    end else begin
      speaker <= speaker_next;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (play_entry[i]) begin
          state_q[i]  <= S_PLAY;
          hp_q[i]     <= entry_hp[i];
          div_q[i]    <= entry_hp[i] - DIV_W'(1);
          tone_out[i] <= 1'b0;
          hold_q[i]   <= '0;
          active[i]   <= 1'b1;
        end else begin
          case (state_q[i])
            S_IDLE: begin
              if (key_in[i]) begin
                state_q[i] <= S_ATTACK;
                hold_q[i]  <= HOLD_ONE;
              end
            end
            S_ATTACK: begin
              if (!key_in[i]) begin
                state_q[i] <= S_IDLE;
                hold_q[i]  <= '0;
              end else begin
                hold_q[i] <= hold_q[i] + HOLD_ONE;
              end
            end
            S_PLAY, S_RELEASE: begin
              // Divider keeps running through RELEASE so a re-press keeps the tone phase.
              if (div_q[i] == '0) begin
                div_q[i]    <= hp_q[i] - DIV_W'(1);
                tone_out[i] <= ~tone_out[i];
              end else begin
                div_q[i] <= div_q[i] - DIV_W'(1);
              end
              if (state_q[i] == S_PLAY) begin
                if (!key_in[i]) begin
                  if (HOLD_CYCLES == 1) begin
                    state_q[i]  <= S_IDLE;
                    hold_q[i]   <= '0;
                    div_q[i]    <= '0;
                    tone_out[i] <= 1'b0;
                    active[i]   <= 1'b0;
                  end else begin
                    state_q[i] <= S_RELEASE;
                    hold_q[i]  <= HOLD_ONE;
                  end
                end else begin
                  hold_q[i] <= '0;
                end
              end else begin
                if (key_in[i]) begin
                  state_q[i] <= S_PLAY;
                  hold_q[i]  <= '0;
                end else if (hold_q[i] == HOLD_LAST) begin
                  state_q[i]  <= S_IDLE;
                  hold_q[i]   <= '0;
                  div_q[i]    <= '0;
                  tone_out[i] <= 1'b0;
                  active[i]   <= 1'b0;
                end else begin
                  hold_q[i] <= hold_q[i] + HOLD_ONE;
                end
              end
            end
            default: begin
              state_q[i] <= S_IDLE;
              hold_q[i]  <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_tone_bank.sv
// Directed bench for tone_bank: checkpoints (edge, signal, value) are queued by the stimulus
// and popped by a negedge monitor that compares them against the DUT outputs.
module tb_tone_bank;
  localparam int NK = 4;
  localparam int DW = 32;

  localparam int K_ACT = 0;
  localparam int K_TONE = 1;
  localparam int K_SPK = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NK-1:0]   key_in = '0;
  logic [NK*DW-1:0] half_period = '0;
  logic [NK-1:0]   tone_out;
  logic [NK-1:0]   active;
  logic            speaker;
`ifdef TONE_BANK_OCTAVE_EN
  logic            octave_up = 1'b0;
`endif

  tone_bank #(.NUM_KEYS(NK), .DIV_W(DW), .HOLD_CYCLES(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .half_period(half_period),
`ifdef TONE_BANK_OCTAVE_EN
    .octave_up  (octave_up),
`endif
    .tone_out   (tone_out),
    .active     (active),
    .speaker    (speaker)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  typedef struct {
    int    cyc;
    int    kind;
    int    idx;
    logic  val;
    string name;
  } exp_t;
  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  function automatic void expect_at(int c, int kind, int idx, logic v, string nm);
    exp_t e;
    int pos;
    e.cyc = c; e.kind = kind; e.idx = idx; e.val = v; e.name = nm;
    pos = exp_q.size();
    while (pos > 0 && exp_q[pos-1].cyc > c) pos--;
    exp_q.insert(pos, e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic got;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      case (e.kind)
        K_ACT:   got = active[e.idx];
        K_TONE:  got = tone_out[e.idx];
        default: got = speaker;
      endcase
      total++;
      if (e.cyc != cyc) begin
        bad++;
        $display("FAIL %s missed checkpoint cyc=%0d now=%0d", e.name, e.cyc, cyc);
      end else if (got !== e.val) begin
        bad++;
        $display("FAIL %s cyc=%0d got=%0b want=%0b", e.name, cyc, got, e.val);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hp(int ch, logic [DW-1:0] v);
    half_period[ch*DW +: DW] = v;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    key_in = '0;
    step();
    step();
    for (int i = 0; i < NK; i++) begin
      expect_at(cyc, K_ACT, i, 1'b0, "reset_active");
      expect_at(cyc, K_TONE, i, 1'b0, "reset_tone");
    end
    expect_at(cyc, K_SPK, 0, 1'b0, "reset_speaker");
    rst = 1'b0;
  endtask

  // Basic tone on ch0 (hp=5, change ignored mid-play) plus a short pulse on ch1.
  task automatic t_basic();
    int b;
    do_reset();
    set_hp(0, 5);
    key_in = 4'b0011;
    b = cyc + 1;
    expect_at(b+1, K_ACT, 0, 1'b0, "basic_act_e1");
    expect_at(b+2, K_ACT, 0, 1'b1, "basic_act_e2");
    expect_at(b+6, K_TONE, 0, 1'b0, "basic_tone_e6");
    expect_at(b+7, K_TONE, 0, 1'b1, "basic_tone_e7");
    expect_at(b+11, K_TONE, 0, 1'b1, "basic_tone_e11");
    expect_at(b+12, K_TONE, 0, 1'b0, "basic_tone_e12");
    expect_at(b+16, K_TONE, 0, 1'b0, "basic_tone_e16");
    expect_at(b+17, K_TONE, 0, 1'b1, "basic_tone_e17");
    expect_at(b+7, K_SPK, 0, 1'b0, "basic_spk_e7");
    expect_at(b+8, K_SPK, 0, 1'b1, "basic_spk_e8");
    expect_at(b+12, K_SPK, 0, 1'b1, "basic_spk_e12");
    expect_at(b+13, K_SPK, 0, 1'b0, "basic_spk_e13");
    for (int n = 1; n <= 4; n++) expect_at(b+n, K_ACT, 1, 1'b0, "pulse_act1");
    expect_at(b+3, K_TONE, 1, 1'b0, "pulse_tone1");
    for (int n = 1; n <= 18; n++) begin
      step();
      if (n == 2) key_in[1] = 1'b0;
      if (n == 9) set_hp(0, 2);
    end
    key_in = '0;
  endtask

  // ch3 outranks ch0 on the speaker until its key is released.
  task automatic t_priority();
    int b;
    do_reset();
    set_hp(0, 5);
    set_hp(3, 3);
    key_in = 4'b1001;
    b = cyc + 1;
    expect_at(b+6, K_SPK, 0, 1'b1, "prio_spk_e6");
    expect_at(b+7, K_SPK, 0, 1'b1, "prio_spk_e7");
    expect_at(b+9, K_SPK, 0, 1'b0, "prio_spk_e9");
    expect_at(b+12, K_SPK, 0, 1'b1, "prio_spk_e12");
    expect_at(b+17, K_ACT, 3, 1'b1, "prio_act3_e17");
    expect_at(b+18, K_ACT, 3, 1'b0, "prio_act3_e18");
    expect_at(b+18, K_SPK, 0, 1'b1, "prio_spk_e18");
    expect_at(b+19, K_SPK, 0, 1'b1, "prio_spk_e19");
    expect_at(b+19, K_TONE, 3, 1'b0, "prio_tone3_e19");
    expect_at(b+23, K_SPK, 0, 1'b0, "prio_spk_e23");
    for (int n = 1; n <= 24; n++) begin
      step();
      key_in[3] = (n <= 15);
    end
    key_in = '0;
  endtask

  // Short release then re-press keeps ch0 active and its tone phase.
  task automatic t_repress();
    int b;
    do_reset();
    set_hp(0, 5);
    key_in = 4'b0001;
    b = cyc + 1;
    for (int n = 8; n <= 10; n++) expect_at(b+n, K_ACT, 0, 1'b1, "repress_act");
    expect_at(b+11, K_TONE, 0, 1'b1, "repress_tone_e11");
    expect_at(b+12, K_TONE, 0, 1'b0, "repress_tone_e12");
    expect_at(b+16, K_TONE, 0, 1'b0, "repress_tone_e16");
    expect_at(b+17, K_TONE, 0, 1'b1, "repress_tone_e17");
    for (int n = 1; n <= 18; n++) begin
      step();
      key_in[0] = !(n == 8 || n == 9);
    end
    key_in = '0;
  endtask

  // Reset pulse while ch0 and ch2 play; both restart after the hold window.
  task automatic t_midreset();
    int b;
    do_reset();
    set_hp(0, 5);
    set_hp(2, 4);
    key_in = 4'b0101;
    b = cyc + 1;
    expect_at(b+9, K_TONE, 2, 1'b1, "mrst_tone2_e9");
    expect_at(b+9, K_SPK, 0, 1'b1, "mrst_spk_e9");
    expect_at(b+10, K_ACT, 0, 1'b0, "mrst_act0_e10");
    expect_at(b+10, K_ACT, 2, 1'b0, "mrst_act2_e10");
    expect_at(b+10, K_TONE, 0, 1'b0, "mrst_tone0_e10");
    expect_at(b+10, K_TONE, 2, 1'b0, "mrst_tone2_e10");
    expect_at(b+10, K_SPK, 0, 1'b0, "mrst_spk_e10");
    expect_at(b+12, K_ACT, 0, 1'b0, "mrst_act0_e12");
    expect_at(b+13, K_ACT, 0, 1'b1, "mrst_act0_e13");
    expect_at(b+13, K_ACT, 2, 1'b1, "mrst_act2_e13");
    expect_at(b+17, K_TONE, 0, 1'b0, "mrst_tone0_e17");
    expect_at(b+18, K_TONE, 0, 1'b1, "mrst_tone0_e18");
    for (int n = 1; n <= 19; n++) begin
      step();
      rst = (n == 10);
    end
    key_in = '0;
  endtask

  // hp=0 toggles every cycle; hp=all-ones must not wrap to a fast tone.
  task automatic t_bounds();
    int b;
    do_reset();
    set_hp(1, 0);
    set_hp(2, 32'hFFFF_FFFF);
    key_in = 4'b0110;
    b = cyc + 1;
    expect_at(b+3, K_TONE, 1, 1'b1, "hp0_tone1_e3");
    expect_at(b+4, K_TONE, 1, 1'b0, "hp0_tone1_e4");
    expect_at(b+5, K_TONE, 1, 1'b1, "hp0_tone1_e5");
    expect_at(b+10, K_SPK, 0, 1'b0, "hpmax_spk_e10");
    expect_at(b+40, K_ACT, 2, 1'b1, "hpmax_act2_e40");
    expect_at(b+40, K_TONE, 2, 1'b0, "hpmax_tone2_e40");
    for (int n = 1; n <= 41; n++) step();
    key_in = '0;
  endtask

`ifdef TONE_BANK_OCTAVE_EN
  task automatic t_octave();
    int b;
    do_reset();
    octave_up = 1'b1;
    set_hp(0, 5);
    key_in = 4'b0001;
    b = cyc + 1;
    expect_at(b+3, K_TONE, 0, 1'b0, "oct_tone_e3");
    expect_at(b+4, K_TONE, 0, 1'b1, "oct_tone_e4");
    expect_at(b+5, K_TONE, 0, 1'b1, "oct_tone_e5");
    expect_at(b+6, K_TONE, 0, 1'b0, "oct_tone_e6");
    for (int n = 1; n <= 8; n++) step();
    key_in = '0;
    octave_up = 1'b0;
  endtask
`endif

  initial begin
    t_basic();
    t_priority();
    t_repress();
    t_midreset();
    t_bounds();
`ifdef TONE_BANK_OCTAVE_EN
    t_octave();
`endif
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) step();
    if (exp_q.size() > 0) begin
      $display("FAIL drain %0d checkpoints never reached", exp_q.size());
      total += exp_q.size();
      bad += exp_q.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
